// File: rtl/game_sequencer.sv
// game_sequencer
// Central controller for the flappy-bird style game. It walks through
// IDLE -> CLEAR -> PLAY -> OVER and produces the timing pulses that move
// the pipe field and the bird. It also keeps the current BCD score and the
// best score seen since reset.
//
// Parameters
//   SHIFT_PERIOD    clk cycles between pipe_shift pulses (2..65535)
//   GRAVITY_PERIOD  clk cycles between bird_down pulses (2..65535)
//
// Ports
//   clk                    system clock, rising edge
//   reset                  synchronous reset, active low
//   start                  single-cycle start/restart pulse
//   flap                   single-cycle flap pulse
//   stop                   collision / out-of-bounds indication
//   incr                   pass-scored indication
//   clear_field            one-cycle pulse that clears the field generators
//   pipe_shift             one-cycle enable that shifts the pipes one column
//   bird_up / bird_down    one-cycle enables that move the bird one row
//   game_active            high while in PLAY
//   game_over              high while in OVER
//   score_tens/score_ones  current score, BCD 00..99
//   best_tens/best_ones    best score since reset, BCD
module game_sequencer #(
    parameter int SHIFT_PERIOD   = 8,
    parameter int GRAVITY_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       flap,
    input  logic       stop,
    input  logic       incr,
    output logic       clear_field,
    output logic       pipe_shift,
    output logic       bird_up,
    output logic       bird_down,
    output logic       game_active,
    output logic       game_over,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] best_tens,
    output logic [3:0] best_ones
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        PLAY,
        OVER
    } state_t;

    localparam logic [15:0] SHIFT_LAST   = 16'(SHIFT_PERIOD - 1);
    localparam logic [15:0] GRAVITY_LAST = 16'(GRAVITY_PERIOD - 1);

    state_t      state;
    logic [15:0] shift_cnt;
    logic [15:0] grav_cnt;

    // Single registered FSM. Every output is assigned from here, so each
    // output reflects the state entered at the same edge. Pulse outputs
    // default low each cycle and are raised only for the cycle they apply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            shift_cnt   <= 16'd0;
            grav_cnt    <= 16'd0;
            clear_field <= 1'b0;
            pipe_shift  <= 1'b0;
            bird_up     <= 1'b0;
            bird_down   <= 1'b0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
            score_tens  <= 4'd0;
            score_ones  <= 4'd0;
            best_tens   <= 4'd0;
            best_ones   <= 4'd0;
        end else begin
            clear_field <= 1'b0;
            pipe_shift  <= 1'b0;
            bird_up     <= 1'b0;
            bird_down   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLEAR;
                        clear_field <= 1'b1;
                        score_tens  <= 4'd0;
                        score_ones  <= 4'd0;
                        shift_cnt   <= 16'd0;
                        grav_cnt    <= 16'd0;
                    end
                end

                CLEAR: begin
                    state       <= PLAY;
                    game_active <= 1'b1;
                    shift_cnt   <= 16'd0;
                    grav_cnt    <= 16'd0;
                end

                PLAY: begin
                    if (stop) begin
                        // A stop wins over start and incr in the same cycle.
                        // BCD digits compare correctly as one 8-bit number.
                        state       <= OVER;
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                        if ({score_tens, score_ones} > {best_tens, best_ones}) begin
                            best_tens <= score_tens;
                            best_ones <= score_ones;
                        end
                    end else begin
                        // The pipe clock free-runs; flaps never disturb it.
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt  <= 16'd0;
                            pipe_shift <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + 16'd1;
                        end

                        // A flap restarts the fall interval and takes the
                        // place of any fall pulse due on the same edge.
                        if (flap) begin
                            bird_up  <= 1'b1;
                            grav_cnt <= 16'd0;
                        end else if (grav_cnt == GRAVITY_LAST) begin
                            grav_cnt  <= 16'd0;
                            bird_down <= 1'b1;
                        end else begin
                            grav_cnt <= grav_cnt + 16'd1;
                        end

                        // Saturating BCD increment; 99 holds.
                        if (incr) begin
                            if (score_ones == 4'd9) begin
                                if (score_tens != 4'd9) begin
                                    score_ones <= 4'd0;
                                    score_tens <= score_tens + 4'd1;
                                end
                            end else begin
                                score_ones <= score_ones + 4'd1;
                            end
                        end
                    end
                end

                OVER: begin
                    if (start) begin
                        state       <= CLEAR;
                        clear_field <= 1'b1;
                        game_over   <= 1'b0;
                        score_tens  <= 4'd0;
                        score_ones  <= 4'd0;
                        shift_cnt   <= 16'd0;
                        grav_cnt    <= 16'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
// Bench for game_sequencer with default periods (pipe 8, gravity 4).
// Stimulus drives inputs on the falling edge and runs a reference model
// built from elapsed-time counts and integer scores. Each cycle's expected
// outputs go into a queue; a separate monitor pops one entry after every
// rising edge and compares it against the DUT outputs.
module tb_game_sequencer;

    localparam int SP = 8;
    localparam int GP = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       flap;
    logic       stop;
    logic       incr;
    logic       clear_field;
    logic       pipe_shift;
    logic       bird_up;
    logic       bird_down;
    logic       game_active;
    logic       game_over;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] best_tens;
    logic [3:0] best_ones;

    typedef struct packed {
        logic [3:0] pulses;   // clear_field, pipe_shift, bird_up, bird_down
        logic [1:0] status;   // game_active, game_over
        logic [7:0] score;
        logic [7:0] best;
    } exp_t;

    exp_t exp_q[$];

    int total;
    int bad;

    // Reference model state
    int m_phase;      // 0 idle, 1 clear, 2 play, 3 over
    int m_t_play;     // edges since PLAY was entered
    int m_t_grav;     // edges since PLAY entry or last flap
    int m_score;
    int m_best;

    game_sequencer #(
        .SHIFT_PERIOD  (SP),
        .GRAVITY_PERIOD(GP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .flap       (flap),
        .stop       (stop),
        .incr       (incr),
        .clear_field(clear_field),
        .pipe_shift (pipe_shift),
        .bird_up    (bird_up),
        .bird_down  (bird_down),
        .game_active(game_active),
        .game_over  (game_over),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .best_tens  (best_tens),
        .best_ones  (best_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic st, input logic i);
        exp_t e;
        @(negedge clk);
        reset = r;
        start = s;
        flap  = f;
        stop  = st;
        incr  = i;
        e = '0;
        if (!r) begin
            m_phase = 0;
            m_score = 0;
            m_best  = 0;
        end else begin
            case (m_phase)
                0: if (s) begin
                    m_phase = 1;
                    m_score = 0;
                    e.pulses[3] = 1'b1;
                end
                1: begin
                    m_phase  = 2;
                    m_t_play = 0;
                    m_t_grav = 0;
                    e.status[1] = 1'b1;
                end
                2: if (st) begin
                    if (m_score > m_best) m_best = m_score;
                    m_phase = 3;
                    e.status[0] = 1'b1;
                end else begin
                    m_t_play++;
                    m_t_grav++;
                    if (i && m_score < 99) m_score++;
                    e.pulses[2] = (m_t_play % SP == 0);
                    if (f) begin
                        e.pulses[1] = 1'b1;
                        m_t_grav = 0;
                    end else begin
                        e.pulses[0] = (m_t_grav % GP == 0);
                    end
                    e.status[1] = 1'b1;
                end
                default: if (s) begin
                    m_phase = 1;
                    m_score = 0;
                    e.pulses[3] = 1'b1;
                end else begin
                    e.status[0] = 1'b1;
                end
            endcase
        end
        e.score = to_bcd(m_score);
        e.best  = to_bcd(m_best);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] p;
        logic [1:0] st;
        p  = {clear_field, pipe_shift, bird_up, bird_down};
        st = {game_active, game_over};
        total++;
        if (p !== e.pulses) begin
            bad++;
            $display("[TB] FAIL pulses t=%0t got=%b want=%b", $time, p, e.pulses);
        end
        total++;
        if (st !== e.status) begin
            bad++;
            $display("[TB] FAIL status t=%0t got=%b want=%b", $time, st, e.status);
        end
        total++;
        if ({score_tens, score_ones} !== e.score) begin
            bad++;
            $display("[TB] FAIL score t=%0t got=%h want=%h", $time, {score_tens, score_ones}, e.score);
        end
        total++;
        if ({best_tens, best_ones} !== e.best) begin
            bad++;
            $display("[TB] FAIL best t=%0t got=%h want=%h", $time, {best_tens, best_ones}, e.best);
        end
    endtask

    // Monitor: outputs are valid every cycle, checked 1 time unit after
    // each rising edge that has a pending prediction.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic incr_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_phase = 0; m_t_play = 0; m_t_grav = 0; m_score = 0; m_best = 0;
        reset = 1'b0; start = 1'b0; flap = 1'b0; stop = 1'b0; incr = 1'b0;

        // Reset, then inputs that must be ignored in IDLE.
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1, 1);

        // Start, free-running pipe and gravity, flap 3 cycles into PLAY.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        idle_cycles(2);
        applyStimulus(1, 0, 1, 0, 0);
        idle_cycles(20);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        idle_cycles(6);

        // Scoring to 12, start in PLAY ignored, then incr+stop together.
        incr_cycles(12);
        applyStimulus(1, 1, 0, 0, 0);
        idle_cycles(2);
        applyStimulus(1, 0, 0, 1, 1);

        // Ignored inputs in OVER.
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1, 1);
        idle_cycles(2);

        // Restart, saturate at 99, start+stop together goes to OVER.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        incr_cycles(100);
        applyStimulus(1, 1, 0, 1, 0);
        idle_cycles(2);

        // Best behaviour after a fresh reset: 05 then 03.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        incr_cycles(5);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        incr_cycles(3);
        applyStimulus(1, 0, 0, 1, 0);

        // Reset mid-PLAY with score 07, and reset during CLEAR.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        incr_cycles(7);
        applyStimulus(0, 0, 1, 0, 1);
        idle_cycles(2);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        idle_cycles(2);

        // Randomized play.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 2) == 0));
        end
        idle_cycles(2);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter SHIFT_PERIOD, default 8: clk cycles between pipe shift pulses, legal range 2..65535.
REQ-003 Parameter GRAVITY_PERIOD, default 4: clk cycles between bird fall pulses, legal range 2..65535.
REQ-004 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous reset, active-low; asserted when 0.
REQ-006 Port start, input, 1 bit: conditioned single-cycle start/restart pulse from the key.
REQ-007 Port flap, input, 1 bit: conditioned single-cycle flap pulse from the key.
REQ-008 Port stop, input, 1 bit: collision or out-of-bounds indication from the score keeper.
REQ-009 Port incr, input, 1 bit: pass-scored indication from the score keeper.
REQ-010 Port clear_field, output, 1 bit: one-cycle pulse that clears the pipe and bird field generators.
REQ-011 Port pipe_shift, output, 1 bit: one-cycle enable that shifts the pipe field one column.
REQ-012 Port bird_up, output, 1 bit: one-cycle enable that moves the bird up one row.
REQ-013 Port bird_down, output, 1 bit: one-cycle enable that moves the bird down one row.
REQ-014 Port game_active, output, 1 bit: high while in PLAY.
REQ-015 Port game_over, output, 1 bit: high while in OVER.
REQ-016 Port score_tens and score_ones, outputs, 4 bits each: current score in BCD, 0..99.
REQ-017 Port best_tens and best_ones, outputs, 4 bits each: best score since reset in BCD.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, PLAY and OVER; all outputs SHALL be registered.
REQ-019 Transition IDLE->CLEAR SHALL occur on start; otherwise the FSM holds in IDLE.
REQ-020 CLEAR SHALL last exactly one cycle, assert clear_field, zero the score, zero both period counters, and go to PLAY.
REQ-021 In PLAY, the shift counter SHALL count 0..SHIFT_PERIOD-1 and wrap; pipe_shift SHALL pulse for one cycle at each wrap, the first pulse SHALL come SHIFT_PERIOD cycles after PLAY entry, and the counter SHALL not restart on flap.
REQ-022 In PLAY, the gravity counter SHALL count 0..GRAVITY_PERIOD-1; bird_down SHALL pulse for one cycle at each wrap.
REQ-023 A flap in PLAY SHALL assert bird_up the next cycle, reset the gravity counter to 0, and suppress any bird_down due that cycle; bird_up and bird_down SHALL never be high together.
REQ-024 An incr cycle in PLAY SHALL add 1 to the BCD score: ones 9->0 with tens+1; the score SHALL saturate at 99, and each asserted cycle SHALL count once.
REQ-025 A stop cycle in PLAY SHALL move the FSM to OVER; if incr is high in the same cycle it SHALL be ignored.
REQ-026 On entry to OVER, best SHALL be updated to the score if the score is strictly greater than best.
REQ-027 OVER SHALL freeze the score and counters and keep all pulse outputs low; start SHALL go to CLEAR (restart).
REQ-028 stop and incr SHALL be ignored outside PLAY; flap SHALL be ignored outside PLAY.
REQ-029 start SHALL be ignored in PLAY and CLEAR.
REQ-030 If start and stop are both high in the same PLAY cycle, the FSM SHALL go to OVER.

Reset
REQ-031 While reset=0 at a rising edge: state SHALL go to IDLE; score and best SHALL go to 00; both counters SHALL go to 0; clear_field, pipe_shift, bird_up, bird_down, game_active and game_over SHALL go to 0.
REQ-032 Reset SHALL take priority over every other input, including mid-PLAY and mid-CLEAR.

Verification
REQ-033 Start after reset: start pulse -> clear_field high 1 cycle, then game_active=1; with SHIFT_PERIOD=8, pipe_shift high every 8th cycle, first 8 cycles after PLAY entry.
REQ-034 Gravity and flap: GRAVITY_PERIOD=4, no flap -> bird_down every 4 cycles; flap 3 cycles into PLAY -> bird_up next cycle, then next bird_down 4 cycles later, no overlap.
REQ-035 Scoring: 12 incr pulses -> score 1/2; 100 pulses -> saturates at 9/9; incr and stop in the same cycle -> score unchanged, game_over=1.
REQ-036 Best and restart: score 05 then stop -> best 05; restart, score 03, stop -> best stays 05; restart clears score to 00.
REQ-037 Ignored inputs: stop, incr and flap in IDLE and OVER -> no state or score change; start in PLAY -> no effect.
REQ-038 Reset mid-PLAY: reset=0 for 1 cycle with score 07 -> IDLE, score 00, best 00, all pulses low.
